// File: rtl/cordic_shift_unit.sv
// cordic_shift_unit: multi-lane signed arithmetic right shifter with a registered valid/ready output stage
module cordic_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int LANES   = 2,
  parameter int SHIFT_W = 5,
  parameter int ITERS   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic                     mode_auto,
  input  logic                     round_en,
  input  logic                     start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [SHIFT_W-1:0]       out_shift,
  output logic                     out_last,
  output logic [SHIFT_W-1:0]       iter_cnt
);
  logic                   r_valid;
  logic                   r_last;
  logic [LANES*WIDTH-1:0] r_data;
  logic [SHIFT_W-1:0]     r_shift;
  logic [SHIFT_W-1:0]     r_iter;
  logic [SHIFT_W-1:0]     w_base;
  logic [SHIFT_W-1:0]     w_s;
  logic [SHIFT_W-1:0]     w_next;
  logic                   w_accept;
  logic                   w_oor;
  logic                   w_last;
  logic [LANES*WIDTH-1:0] w_res;

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // start overrides the held count so a same-cycle beat already sees iteration 0
  assign w_base    = start ? '0 : r_iter;
  assign w_s       = mode_auto ? w_base : in_shift;
  assign w_next    = (w_base == SHIFT_W'(ITERS - 1)) ? '0 : w_base + 1'b1;
  assign w_oor     = 32'(w_s) >= 32'(WIDTH);
  assign w_last    = mode_auto && (w_s == SHIFT_W'(ITERS - 1));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH-1:0] w_trunc;
    logic signed [WIDTH:0]   w_ext;
    logic signed [WIDTH:0]   w_bias;
    logic signed [WIDTH:0]   w_sum;
    logic        [WIDTH-1:0] w_rnd;
    assign w_x     = in_data[k*WIDTH +: WIDTH];
    assign w_trunc = w_x >>> w_s;
    // one extra bit keeps x + half-LSB from overflowing before the shift
    assign w_ext   = {w_x[WIDTH-1], w_x};
    assign w_bias  = (w_s == '0 || w_oor) ? '0 : (WIDTH+1)'(1) << (w_s - 1'b1);
    assign w_sum   = w_ext + w_bias;
    assign w_rnd   = WIDTH'(w_sum >>> w_s);
    assign w_res[k*WIDTH +: WIDTH] = w_oor ? (round_en ? '0 : {WIDTH{w_x[WIDTH-1]}})
                                           : (round_en ? w_rnd : w_trunc);
  end

  // output stage: capture on accept, hold otherwise; counter advances only on auto-mode accepts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_iter  <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= w_res;
        r_shift <= w_s;
        r_last  <= w_last;
      end
      r_valid <= w_accept ? 1'b1 : (out_ready ? 1'b0 : r_valid);
      r_iter  <= (w_accept && mode_auto) ? w_next : w_base;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_shift = r_shift;
  assign out_last  = r_last;
  assign iter_cnt  = r_iter;
endmodule
